// File: rtl/axi_rd_arbiter_pkg.sv
// Shared AXI constants, requester indices and arbiter state encoding.
package axi_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    localparam int unsigned REQ_ICACHE   = 0;
    localparam int unsigned REQ_DCACHE   = 1;
    localparam int unsigned REQ_UNCACHED = 2;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_ISSUE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/axi_rd_arbiter_select.sv
// Combinational grant selection from the eligible vector.
// AXI_RD_ARB_RR_EN defined: round-robin search starting at ptr.
// AXI_RD_ARB_RR_EN undefined: fixed priority, lowest index wins.
module arb_select #(
    parameter int unsigned N_MASTER = 3,
    parameter int unsigned IDX_W    = 2
) (
    input  logic [N_MASTER-1:0] eligible,
`ifdef AXI_RD_ARB_RR_EN
    input  logic [IDX_W-1:0]    ptr,
`endif
    output logic [IDX_W-1:0]    idx,
    output logic                any
);

`ifdef AXI_RD_ARB_RR_EN
    // First eligible requester at or after ptr, wrapping at N_MASTER
    always_comb begin : sel_rr
        int unsigned j;
        j   = 0;
        idx = '0;
        any = 1'b0;
        for (int unsigned k = 0; k < N_MASTER; k++) begin
            j = (32'(ptr) + k) % N_MASTER;
            if (!any && eligible[j]) begin
                any = 1'b1;
                idx = IDX_W'(j);
            end
        end
    end
`else
    // Lowest-index eligible requester
    always_comb begin : sel_fixed
        idx = '0;
        any = 1'b0;
        for (int unsigned k = 0; k < N_MASTER; k++) begin
            if (!any && eligible[k]) begin
                any = 1'b1;
                idx = IDX_W'(k);
            end
        end
    end
`endif

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI AR/R channel pair between the CPU read requesters.
// Each requester has at most one burst outstanding; its index is the ARID.
// Optional macro AXI_RD_ARB_RR_EN selects round-robin instead of fixed priority.
module axi_rd_arbiter
    import axi_pkg::*;
#(
    parameter int unsigned N_MASTER   = 3,
    parameter int unsigned ID_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [N_MASTER-1:0]            m_arvalid,
    input  logic [N_MASTER*ADDR_WIDTH-1:0] m_araddr,
    input  logic [N_MASTER*8-1:0]          m_arlen,
    input  logic [N_MASTER*3-1:0]          m_arsize,
    output logic [N_MASTER-1:0]            m_arready,
    output logic [N_MASTER-1:0]            m_rvalid,
    input  logic [N_MASTER-1:0]            m_rready,
    output logic [31:0]                    m_rdata,
    output logic [1:0]                     m_rresp,
    output logic                           m_rlast,
    output logic [ID_WIDTH-1:0]            arid,
    output logic [ADDR_WIDTH-1:0]          araddr,
    output logic [7:0]                     arlen,
    output logic [2:0]                     arsize,
    output logic [1:0]                     arburst,
    output logic                           arvalid,
    input  logic                           arready,
    input  logic [ID_WIDTH-1:0]            rid,
    input  logic [31:0]                    rdata,
    input  logic [1:0]                     rresp,
    input  logic                           rlast,
    input  logic                           rvalid,
    output logic                           rready
);

    localparam int unsigned IDX_W = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;

    arb_state_t            state, state_next;
    logic [IDX_W-1:0]      grant, grant_next;
    logic [N_MASTER-1:0]   busy, busy_clr;
    logic [N_MASTER-1:0]   eligible;
    logic [IDX_W-1:0]      sel_idx;
    logic                  sel_any;

    // Eligibility uses registered busy, so a requester whose burst ends this
    // cycle can only be re-granted from the next evaluation onward.
    assign eligible = m_arvalid & ~busy;

`ifdef AXI_RD_ARB_RR_EN
    logic [IDX_W-1:0] rr_ptr;

    // Round-robin pointer moves past the requester that just handshook
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
        end else if (|m_arready) begin
            rr_ptr <= (grant == IDX_W'(N_MASTER - 1)) ? '0 : grant + 1'b1;
        end
    end
`endif

    arb_select #(
        .N_MASTER (N_MASTER),
        .IDX_W    (IDX_W)
    ) u_select (
        .eligible (eligible),
`ifdef AXI_RD_ARB_RR_EN
        .ptr      (rr_ptr),
`endif
        .idx      (sel_idx),
        .any      (sel_any)
    );

    // State, grant and outstanding-burst registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB_IDLE;
            grant <= '0;
            busy  <= '0;
        end else begin
            state <= state_next;
            grant <= grant_next;
            busy  <= (busy & ~busy_clr) | m_arready;
        end
    end

    // Arbitration FSM: latch a grant in IDLE, present the granted AR in ISSUE
    always_comb begin
        state_next = state;
        grant_next = grant;
        arvalid    = 1'b0;
        araddr     = '0;
        arlen      = '0;
        arsize     = '0;
        m_arready  = '0;
        case (state)
            ARB_IDLE: begin
                if (sel_any) begin
                    state_next = ARB_ISSUE;
                    grant_next = sel_idx;
                end
            end
            ARB_ISSUE: begin
                for (int unsigned i = 0; i < N_MASTER; i++) begin
                    if (grant == IDX_W'(i)) begin
                        arvalid      = m_arvalid[i];
                        araddr       = m_araddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                        arlen        = m_arlen[i*8 +: 8];
                        arsize       = m_arsize[i*3 +: 3];
                        m_arready[i] = m_arvalid[i] && arready;
                    end
                end
                if (arvalid && arready) begin
                    state_next = ARB_IDLE;
                end
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    // R routing by RID; beats with an unknown ID are accepted and dropped
    always_comb begin
        m_rvalid = '0;
        rready   = 1'b1;
        busy_clr = '0;
        for (int unsigned i = 0; i < N_MASTER; i++) begin
            if (rid == ID_WIDTH'(i)) begin
                m_rvalid[i] = rvalid;
                rready      = m_rready[i];
                busy_clr[i] = rvalid && m_rready[i] && rlast;
            end
        end
    end

    assign arid    = ID_WIDTH'(grant);
    assign arburst = AXI_BURST_INCR;
    assign m_rdata = rdata;
    assign m_rresp = rresp;
    assign m_rlast = rlast;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed self-checking bench for axi_rd_arbiter (N_MASTER=3).
// Expected grant order is chosen so it holds with and without AXI_RD_ARB_RR_EN.
module tb_axi_rd_arbiter;

    localparam int N  = 3;
    localparam int IW = 4;
    localparam int AW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    m_arvalid;
    logic [N*AW-1:0] m_araddr;
    logic [N*8-1:0]  m_arlen;
    logic [N*3-1:0]  m_arsize;
    logic [N-1:0]    m_arready;
    logic [N-1:0]    m_rvalid;
    logic [N-1:0]    m_rready;
    logic [31:0]     m_rdata;
    logic [1:0]      m_rresp;
    logic            m_rlast;
    logic [IW-1:0]   arid;
    logic [AW-1:0]   araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arvalid;
    logic            arready;
    logic [IW-1:0]   rid;
    logic [31:0]     rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    int n_checks = 0;
    int n_fail   = 0;

    axi_rd_arbiter #(
        .N_MASTER   (N),
        .ID_WIDTH   (IW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .m_arvalid (m_arvalid),
        .m_araddr  (m_araddr),
        .m_arlen   (m_arlen),
        .m_arsize  (m_arsize),
        .m_arready (m_arready),
        .m_rvalid  (m_rvalid),
        .m_rready  (m_rready),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rlast   (m_rlast),
        .arid      (arid),
        .araddr    (araddr),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .arvalid   (arvalid),
        .arready   (arready),
        .rid       (rid),
        .rdata     (rdata),
        .rresp     (rresp),
        .rlast     (rlast),
        .rvalid    (rvalid),
        .rready    (rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rv;
        logic [IW-1:0] id;
        logic [N-1:0]  rdy;
        logic [N-1:0]  exp_mrv;
        logic          exp_rready;
    } rvec_t;

    rvec_t vecs[8];

    logic [AW-1:0] addrs[N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m_arvalid = '0;
        m_arready_dummy();
        arready   = 1'b0;
        rid       = '0;
        rdata     = '0;
        rresp     = '0;
        rlast     = 1'b0;
        rvalid    = 1'b0;
        m_rready  = '0;
    endtask

    task automatic m_arready_dummy();
        m_araddr = '0;
        m_arlen  = '0;
        m_arsize = '0;
        for (int i = 0; i < N; i++) begin
            m_araddr[i*AW +: AW] = addrs[i];
            m_arlen[i*8 +: 8]    = 8'(4 * i + 3);
            m_arsize[i*3 +: 3]   = 3'd2;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        addrs[0] = 32'h1FC0_0000;
        addrs[1] = 32'h0000_1040;
        addrs[2] = 32'hBFD0_0008;

        //               rv id     rdy     mrv     rready
        vecs[0] = '{1'b1, 4'd0,  3'b111, 3'b001, 1'b1};
        vecs[1] = '{1'b1, 4'd1,  3'b101, 3'b010, 1'b0};
        vecs[2] = '{1'b1, 4'd2,  3'b100, 3'b100, 1'b1};
        vecs[3] = '{1'b1, 4'd2,  3'b011, 3'b100, 1'b0};
        vecs[4] = '{1'b1, 4'd3,  3'b111, 3'b000, 1'b1};
        vecs[5] = '{1'b1, 4'd15, 3'b000, 3'b000, 1'b1};
        vecs[6] = '{1'b0, 4'd1,  3'b010, 3'b000, 1'b1};
        vecs[7] = '{1'b0, 4'd0,  3'b000, 3'b000, 1'b0};

        // Reset state
        do_reset();
        chk("rst_arvalid", 64'(arvalid), 64'd0);
        chk("rst_m_arready", 64'(m_arready), 64'd0);
        chk("rst_m_rvalid", 64'(m_rvalid), 64'd0);
        chk("rst_rready", 64'(rready), 64'd0);
        chk("rst_arburst", 64'(arburst), 64'd1);
        chk("rst_arid", 64'(arid), 64'd0);
        chk("rst_busy", 64'(dut.busy), 64'd0);

        // R routing table (rlast low so busy is untouched)
        for (int v = 0; v < 8; v++) begin
            rvalid   = vecs[v].rv;
            rid      = vecs[v].id;
            m_rready = vecs[v].rdy;
            #1;
            chk($sformatf("tbl%0d_m_rvalid", v), 64'(m_rvalid), 64'(vecs[v].exp_mrv));
            chk($sformatf("tbl%0d_rready", v), 64'(rready), 64'(vecs[v].exp_rready));
            tick();
        end
        clear_inputs();
        tick();

        // Single request, 16-beat burst to requester 0
        m_araddr[0 +: AW] = 32'h1FC0_0000;
        m_arlen[0 +: 8]   = 8'd15;
        m_arvalid         = 3'b001;
        arready           = 1'b1;
        #1;
        chk("single_latency_arvalid", 64'(arvalid), 64'd0);
        tick();
        chk("single_arvalid", 64'(arvalid), 64'd1);
        chk("single_arid", 64'(arid), 64'd0);
        chk("single_arlen", 64'(arlen), 64'd15);
        chk("single_araddr", 64'(araddr), 64'h1FC0_0000);
        chk("single_arsize", 64'(arsize), 64'd2);
        chk("single_m_arready", 64'(m_arready), 64'b001);
        tick();
        m_arvalid = '0;
        #1;
        chk("single_post_arvalid", 64'(arvalid), 64'd0);
        chk("single_busy_set", 64'(dut.busy), 64'b001);
        m_rready = 3'b111;
        for (int b = 0; b < 16; b++) begin
            rvalid = 1'b1;
            rid    = 4'd0;
            rdata  = 32'hA500_0000 + 32'(b);
            rlast  = (b == 15);
            #1;
            chk($sformatf("beat%0d_m_rvalid", b), 64'(m_rvalid), 64'b001);
            chk($sformatf("beat%0d_m_rdata", b), 64'(m_rdata), 64'(32'hA500_0000 + 32'(b)));
            if (b == 15) chk("beat15_m_rlast", 64'(m_rlast), 64'd1);
            tick();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        #1;
        chk("single_busy_clear", 64'(dut.busy), 64'd0);

        // Contention: all three request, grants follow 0, 1, 2
        do_reset();
        m_arvalid = 3'b111;
        arready   = 1'b1;
        for (int g = 0; g < N; g++) begin
            #1;
            chk($sformatf("cont%0d_idle_arvalid", g), 64'(arvalid), 64'd0);
            tick();
            chk($sformatf("cont%0d_arvalid", g), 64'(arvalid), 64'd1);
            chk($sformatf("cont%0d_arid", g), 64'(arid), 64'(g));
            chk($sformatf("cont%0d_araddr", g), 64'(araddr), 64'(addrs[g]));
            chk($sformatf("cont%0d_arlen", g), 64'(arlen), 64'(4 * g + 3));
            chk($sformatf("cont%0d_m_arready", g), 64'(m_arready), 64'(1 << g));
            tick();
        end
        tick();
        chk("cont_busy_all", 64'(dut.busy), 64'b111);
        chk("cont_no_more_arvalid", 64'(arvalid), 64'd0);

        // Stall: grant held on requester 1 while others join
        do_reset();
        m_arvalid = 3'b010;
        arready   = 1'b0;
        tick();
        m_arvalid = 3'b111;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("stall%0d_arvalid", c), 64'(arvalid), 64'd1);
            chk($sformatf("stall%0d_arid", c), 64'(arid), 64'd1);
            chk($sformatf("stall%0d_araddr", c), 64'(araddr), 64'(addrs[1]));
            chk($sformatf("stall%0d_m_arready", c), 64'(m_arready), 64'd0);
            tick();
        end
        arready = 1'b1;
        #1;
        chk("stall_release_m_arready", 64'(m_arready), 64'b010);
        tick();
        m_arvalid = '0;
        #1;
        chk("stall_busy", 64'(dut.busy), 64'b010);

        // Interleaved R beats for requesters 0 and 1
        do_reset();
        m_arvalid = 3'b011;
        arready   = 1'b1;
        tick(); tick(); tick(); tick();
        m_arvalid = '0;
        #1;
        chk("ilv_busy_start", 64'(dut.busy), 64'b011);
        m_rready = 3'b011;
        begin
            logic [IW-1:0] ids[4];
            logic          lasts[4];
            logic [N-1:0]  busy_after[4];
            ids   = '{4'd1, 4'd0, 4'd0, 4'd1};
            lasts = '{1'b0, 1'b0, 1'b1, 1'b0};
            busy_after = '{3'b011, 3'b011, 3'b010, 3'b010};
            for (int b = 0; b < 4; b++) begin
                rvalid = 1'b1;
                rid    = ids[b];
                rlast  = lasts[b];
                #1;
                chk($sformatf("ilv%0d_m_rvalid", b), 64'(m_rvalid), 64'(1 << ids[b]));
                chk($sformatf("ilv%0d_rready", b), 64'(rready), 64'd1);
                tick();
                chk($sformatf("ilv%0d_busy", b), 64'(dut.busy), 64'(busy_after[b]));
            end
        end

        // Backpressure on rid=2, then an unknown-ID beat is dropped
        rvalid   = 1'b1;
        rid      = 4'd2;
        rlast    = 1'b1;
        m_rready = 3'b011;
        #1;
        chk("bp_rready", 64'(rready), 64'd0);
        chk("bp_m_rvalid", 64'(m_rvalid), 64'b100);
        tick();
        chk("bp_hold_rready", 64'(rready), 64'd0);
        chk("bp_hold_m_rvalid", 64'(m_rvalid), 64'b100);
        rid = 4'd7;
        #1;
        chk("unk_rready", 64'(rready), 64'd1);
        chk("unk_m_rvalid", 64'(m_rvalid), 64'd0);
        tick();
        rvalid = 1'b0;
        rlast  = 1'b0;
        #1;
        chk("unk_busy_unchanged", 64'(dut.busy), 64'b010);

        // Reset while an AR is presented and a burst is outstanding
        m_arvalid = 3'b101;
        arready   = 1'b0;
        tick();
        chk("mid_arvalid", 64'(arvalid), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("mid_rst_arvalid", 64'(arvalid), 64'd0);
        chk("mid_rst_busy", 64'(dut.busy), 64'd0);
        tick();
        chk("mid_rearb_arvalid", 64'(arvalid), 64'd1);
        chk("mid_rearb_arid", 64'(arid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Shares the single AXI read address and read data channels between the CPU-side read requesters: I-cache refill, D-cache refill and uncached data load.
- Sits inside the SRAM-to-AXI bridge, between the per-requester read engines and the top-level AR/R ports.
- Each requester may have at most one outstanding burst. Its index is used as ARID, and R beats are routed back by RID.

Parameters:
- N_MASTER, 3, number of read requesters; index 0 = I-cache, 1 = D-cache, 2 = uncached. Must be ≤ 2**ID_WIDTH.
- ID_WIDTH, 4, AXI ID width.
- ADDR_WIDTH, 32, address width.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- m_arvalid  in  N_MASTER  per-requester read request.
- m_araddr  in  N_MASTER*ADDR_WIDTH  request address, packed with requester i at slice i.
- m_arlen  in  N_MASTER*8  burst length minus 1.
- m_arsize  in  N_MASTER*3  beat size.
- m_arready  out  N_MASTER  request accepted; one-hot pulse.
- m_rvalid  out  N_MASTER  beat valid for requester i.
- m_rready  in  N_MASTER  requester i can accept a beat.
- m_rdata  out  32  beat data, broadcast to all requesters.
- m_rresp  out  2  beat response, broadcast.
- m_rlast  out  1  last beat, broadcast.
- arid  out  ID_WIDTH  ID of the granted requester.
- araddr  out  ADDR_WIDTH  AXI read address.
- arlen  out  8  AXI burst length.
- arsize  out  3  AXI beat size.
- arburst  out  2  fixed 2'b01 (INCR).
- arvalid  out  1  AXI address valid.
- arready  in  1  AXI address ready.
- rid  in  ID_WIDTH  AXI read ID.
- rdata  in  32  AXI read data.
- rresp  in  2  AXI read response.
- rlast  in  1  AXI last beat.
- rvalid  in  1  AXI beat valid.
- rready  out  1  AXI beat ready.

Behaviour:
- State:
  - hold (1b): an AR is currently presented.
  - grant (index register).
  - busy[N_MASTER]: requester has a burst outstanding.
  - rr_ptr: round-robin pointer.
- Reset: hold=0, grant=0, busy=0, rr_ptr=0. All outputs then read 0 except arburst=01 and arid=0: arvalid, m_arready, m_rvalid and rready are all 0.
- IDLE (hold=0):
  - Eligible set = m_arvalid & ~busy.
  - If the set is non-empty, register the chosen index into grant and set hold=1 next cycle. Latency is 1 cycle from m_arvalid to arvalid.
- ISSUE (hold=1):
  - arvalid = m_arvalid[grant]; araddr/arlen/arsize are muxed combinationally from requester grant; arid = grant zero-extended.
  - Requesters must hold their request stable until m_arready; dropping it earlier is illegal.
  - On arvalid&&arready: m_arready[grant]=1 in the same cycle, busy[grant] set, hold cleared, rr_ptr = grant+1 (wrapping at N_MASTER).
  - Grant never changes while hold=1 (AXI stability rule).
- R routing:
  - m_rvalid[i] = rvalid && rid==i.
  - rready = m_rready[rid] when rid<N_MASTER, else 1 (unknown ID beats are consumed and dropped).
  - Beat handshake with rlast and rid==i clears busy[i].
- Simultaneous events:
  - busy clear and a new eligibility evaluation in the same cycle: evaluation uses the pre-clear busy, so the requester is re-granted one cycle later at the earliest.
  - AR handshake and an R last beat for a different ID in the same cycle: both take effect.
- No combinational path from arready to arvalid.
- Reset mid-burst clears all state. The AXI slave is reset by the same reset, so no stale beats are expected.

Optional Feature:
- Macro AXI_RD_ARB_RR_EN.
- Defined: round-robin selection, starting search at rr_ptr.
- Undefined: fixed priority, lowest index wins (I-cache first); rr_ptr logic is removed.

Decomposition:
- Package axi_pkg holds:
  - AXI_BURST_INCR=2'b01
  - AXI_RESP_OKAY=2'b00
  - requester index constants REQ_ICACHE=0, REQ_DCACHE=1, REQ_UNCACHED=2
- One sub-module, arb_select: combinational eligible-vector + pointer → one-hot/index grant. It holds both the round-robin and fixed-priority variants under the macro.

Test Plan:
- Single request: m_arvalid=001, addr 0x1FC0_0000, len 15, arready=1 → arvalid one cycle later with arid=0, arlen=15; m_arready=001 in the same cycle; 16 R beats with rid=0 reach requester 0 only; busy[0] clears on rlast.
- Contention: m_arvalid=111, arready=1 → with RR_EN, grants are 0, 1, 2. Without it, grants are 0, 1, 2 only because busy masks the granted requester.
- Stall: arready=0 for 5 cycles while other requesters assert → arvalid, araddr and arid stay stable; the grant does not switch.
- Interleaved R: rid alternates 1, 0, 0, 1 with m_rready=011 → m_rvalid follows rid; busy[0] clears on rid=0 rlast while busy[1] stays set.
- Backpressure: rid=2, m_rready[2]=0 → rready=0, beat held; rid=7 → rready=1, beat dropped, no m_rvalid.
- Reset mid-ISSUE and mid-burst → next cycle arvalid=0, busy=000, and re-arbitration starts from index 0.
